nn_layer_engine: RTL and testbench

Parametrised, time-multiplexed perceptron layer: N_NEURON neurons, each with N_IN signed inputs. Weights, biases, thresholds and inputs load over one byte stream. One shared multiply-accumulate unit evaluates the layer serially. Results go into a readable output bank. This block is the scalable successor to the fixed 4×4 parallel-perceptron top: it sits between the pin-level command decoder and the output mux, and trades latency for area.

---
 rtl/nn_layer_engine_if.sv | 30 +++
 rtl/nn_layer_engine.sv | 251 +++++++++++++++++++++++++
 tb/tb_nn_layer_engine.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_layer_engine_if.sv
// nn_layer_engine_if
//   Command, load-stream and output-bank read signals of nn_layer_engine.
//   master: the command decoder side (drives commands, load beats and rd_sel).
//   slave : the layer engine (drives ready/busy/done and rd_data).
//   Parameters: DW (data width), SEL_W (rd_sel width).
interface nn_layer_engine_if #(
  parameter int DW    = 8,
  parameter int SEL_W = 2
);
  logic             cmd_valid;
  logic [1:0]       cmd;
  logic             cmd_ready;
  logic             data_valid;
  logic [DW-1:0]    data_in;
  logic             data_ready;
  logic             busy;
  logic             done;
  logic [SEL_W-1:0] rd_sel;
  logic [DW-1:0]    rd_data;

  modport master (
    output cmd_valid, cmd, data_valid, data_in, rd_sel,
    input  cmd_ready, data_ready, busy, done, rd_data
  );

  modport slave (
    input  cmd_valid, cmd, data_valid, data_in, rd_sel,
    output cmd_ready, data_ready, busy, done, rd_data
  );
endinterface

// File: rtl/nn_layer_engine.sv
// nn_layer_engine
//   Time-multiplexed perceptron layer: N_NEURON neurons of N_IN signed inputs,
//   evaluated serially on one shared multiply-accumulate unit.
//   Ports:
//     clk    - sole clock, rising edge
//     rst_n  - synchronous active-low reset
//     bus    - nn_layer_engine_if.slave: cmd_valid/cmd/cmd_ready,
//              data_valid/data_in/data_ready, busy, done, rd_sel/rd_data
//   Build option: define NN_RELU_EN for a saturating ReLU-with-threshold
//   activation; otherwise a 0/1 step activation is built.
//
//   state        | meaning
//   -------------+---------------------------------------------------------
//   S_IDLE       | waiting for a command; only state with cmd_ready=1
//   S_LOAD_PARAM | taking N_NEURON*(N_IN+2) beats: w[n][*], bias[n], th[n]
//   S_LOAD_INPUT | taking N_IN beats: x[0..N_IN-1]
//   S_COMPUTE    | per neuron: N_IN MAC cycles, then write + next init
module nn_layer_engine #(
  parameter int N_IN     = 4,
  parameter int N_NEURON = 4,
  parameter int DW       = 8,
  parameter int ACC_W    = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  nn_layer_engine_if.slave   bus
);

  localparam int IW    = $clog2(N_IN + 2);
  localparam int NW    = (N_NEURON > 1) ? $clog2(N_NEURON) : 1;
  localparam int SEL_W = NW;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_LOAD_PARAM = 2'd1,
    S_LOAD_INPUT = 2'd2,
    S_COMPUTE    = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [NW-1:0]             neu_q, neu_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      done_q, done_d;

  logic signed [DW-1:0]      w_q    [N_NEURON][N_IN];
  logic signed [DW-1:0]      w_d    [N_NEURON][N_IN];
  logic signed [DW-1:0]      bias_q [N_NEURON];
  logic signed [DW-1:0]      bias_d [N_NEURON];
  logic signed [DW-1:0]      th_q   [N_NEURON];
  logic signed [DW-1:0]      th_d   [N_NEURON];
  logic signed [DW-1:0]      x_q    [N_IN];
  logic signed [DW-1:0]      x_d    [N_IN];
  logic [DW-1:0]             out_q  [N_NEURON];
  logic [DW-1:0]             out_d  [N_NEURON];

  logic signed [DW-1:0]      x_sel, w_sel, th_sel, bias_nxt;
  logic [NW-1:0]             bias_idx;
  logic signed [2*DW-1:0]    prod;
  logic signed [ACC_W-1:0]   prod_ext, bias_ext, th_ext;
  logic                      ge;
  logic [DW-1:0]             act_val;
  logic [DW-1:0]             rd_val;

  // Operand selection. Loop-based muxes keep every index width exact for
  // any N_IN / N_NEURON. The bias fetched is for neuron 0 when a RUN is
  // accepted in IDLE, otherwise for the neuron after the current one
  // (its init shares the cycle with the current neuron's write).
  always_comb begin
    x_sel    = '0;
    w_sel    = '0;
    th_sel   = '0;
    bias_nxt = '0;
    bias_idx = (state_q == S_COMPUTE) ? neu_q + NW'(1) : '0;
    for (int i = 0; i < N_IN; i++) begin
      if (idx_q == IW'(i)) x_sel = x_q[i];
    end
    for (int n = 0; n < N_NEURON; n++) begin
      for (int i = 0; i < N_IN; i++) begin
        if (neu_q == NW'(n) && idx_q == IW'(i)) w_sel = w_q[n][i];
      end
      if (neu_q == NW'(n))    th_sel   = th_q[n];
      if (bias_idx == NW'(n)) bias_nxt = bias_q[n];
    end
  end

  always_comb begin
    prod     = $signed({{DW{x_sel[DW-1]}}, x_sel}) * $signed({{DW{w_sel[DW-1]}}, w_sel});
    prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
    bias_ext = {{(ACC_W-DW){bias_nxt[DW-1]}}, bias_nxt};
    th_ext   = {{(ACC_W-DW){th_sel[DW-1]}}, th_sel};
    ge       = (acc_q >= th_ext);
  end

`ifdef NN_RELU_EN
  logic fits;
  always_comb begin
    // acc fits in DW bits when everything from bit DW-1 upward is a copy
    // of the sign.
    fits = (&acc_q[ACC_W-1:DW-1]) | ~(|acc_q[ACC_W-1:DW-1]);
    if (!ge)
      act_val = '0;
    else if (fits)
      act_val = acc_q[DW-1:0];
    else if (acc_q[ACC_W-1])
      act_val = {1'b1, {(DW-1){1'b0}}};
    else
      act_val = {1'b0, {(DW-1){1'b1}}};
  end
`else
  always_comb begin
    act_val = ge ? DW'(1) : '0;
  end
`endif

  always_comb begin
    state_d = state_q;
    neu_d   = neu_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    w_d     = w_q;
    bias_d  = bias_q;
    th_d    = th_q;
    x_d     = x_q;
    out_d   = out_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd)
            2'b01: begin
              state_d = S_LOAD_PARAM;
              neu_d   = '0;
              idx_d   = '0;
            end
            2'b10: begin
              state_d = S_LOAD_INPUT;
              idx_d   = '0;
            end
            2'b11: begin
              // The accepting edge doubles as the init cycle of neuron 0.
              state_d = S_COMPUTE;
              neu_d   = '0;
              idx_d   = '0;
              acc_d   = bias_ext;
            end
            default: ;
          endcase
        end
      end

      S_LOAD_PARAM: begin
        if (bus.data_valid) begin
          for (int n = 0; n < N_NEURON; n++) begin
            if (neu_q == NW'(n)) begin
              for (int i = 0; i < N_IN; i++) begin
                if (idx_q == IW'(i)) w_d[n][i] = bus.data_in;
              end
              if (idx_q == IW'(N_IN))     bias_d[n] = bus.data_in;
              if (idx_q == IW'(N_IN + 1)) th_d[n]   = bus.data_in;
            end
          end
          if (idx_q == IW'(N_IN + 1)) begin
            idx_d = '0;
            if (neu_q == NW'(N_NEURON - 1)) state_d = S_IDLE;
            else                            neu_d   = neu_q + NW'(1);
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      S_LOAD_INPUT: begin
        if (bus.data_valid) begin
          for (int i = 0; i < N_IN; i++) begin
            if (idx_q == IW'(i)) x_d[i] = bus.data_in;
          end
          if (idx_q == IW'(N_IN - 1)) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end

      S_COMPUTE: begin
        if (idx_q != IW'(N_IN)) begin
          acc_d = acc_q + prod_ext;
          idx_d = idx_q + IW'(1);
        end else begin
          for (int n = 0; n < N_NEURON; n++) begin
            if (neu_q == NW'(n)) out_d[n] = act_val;
          end
          idx_d = '0;
          if (neu_q == NW'(N_NEURON - 1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            neu_d = neu_q + NW'(1);
            acc_d = bias_ext;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      neu_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
      w_q     <= '{default: '0};
      bias_q  <= '{default: '0};
      th_q    <= '{default: '0};
      x_q     <= '{default: '0};
      out_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      neu_q   <= neu_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      w_q     <= w_d;
      bias_q  <= bias_d;
      th_q    <= th_d;
      x_q     <= x_d;
      out_q   <= out_d;
    end
  end

  // Out-of-range rd_sel matches no entry and reads 0.
  always_comb begin
    rd_val = '0;
    for (int n = 0; n < N_NEURON; n++) begin
      if (bus.rd_sel == SEL_W'(n)) rd_val = out_q[n];
    end
  end

  assign bus.rd_data    = rd_val;
  assign bus.cmd_ready  = (state_q == S_IDLE);
  assign bus.data_ready = (state_q == S_LOAD_PARAM) || (state_q == S_LOAD_INPUT);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = done_q;

endmodule

// File: tb/tb_nn_layer_engine.sv
// tb_nn_layer_engine
//   Self-checking bench for nn_layer_engine with default parameters
//   (4 neurons x 4 inputs, DW=8, ACC_W=20). Expected outputs follow the
//   NN_RELU_EN build selection.
module tb_nn_layer_engine;
  localparam int N_IN     = 4;
  localparam int N_NEURON = 4;
  localparam int DW       = 8;
  localparam int ACC_W    = 20;
  localparam int SEL_W    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nn_layer_engine_if #(.DW(DW), .SEL_W(SEL_W)) bus ();

  nn_layer_engine #(
    .N_IN(N_IN), .N_NEURON(N_NEURON), .DW(DW), .ACC_W(ACC_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic [15:0][7:0] w;       // w[n*4+i]
    logic [3:0][7:0]  b;
    logic [3:0][7:0]  th;
    logic [3:0][7:0]  x;
    logic [3:0][7:0]  exp_out;
  } vec_t;

  vec_t       vecs [4];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] c);
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd       = 2'b00;
  endtask

  task automatic beat(input logic [7:0] d);
    bus.data_valid = 1'b1;
    bus.data_in    = d;
    tick();
    bus.data_valid = 1'b0;
  endtask

  task automatic load_params(input vec_t v, input bit stall);
    logic [7:0] pb [$];
    for (int n = 0; n < N_NEURON; n++) begin
      for (int i = 0; i < N_IN; i++) pb.push_back(v.w[n*4+i]);
      pb.push_back(v.b[n]);
      pb.push_back(v.th[n]);
    end
    issue(2'b01);
    for (int k = 0; k < pb.size(); k++) begin
      if (stall) begin
        bus.data_valid = 1'b0;
        bus.data_in    = 8'hA5;
        tick();
      end
      beat(pb[k]);
      if (stall)
        check($sformatf("stall_beat%0d_cmd_ready", k), 32'(bus.cmd_ready),
              (k == pb.size() - 1) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic load_inputs(input vec_t v);
    issue(2'b10);
    for (int i = 0; i < N_IN; i++) beat(v.x[i]);
  endtask

  // Issues RUN, pushes expected outputs, measures done latency and reads
  // the bank back through the scoreboard. hold_cmd keeps an illegal
  // LOAD_PARAM request asserted during the first part of COMPUTE.
  task automatic run_check(input string tag, input logic [3:0][7:0] expv, input bit hold_cmd);
    int cyc;
    bit seen;
    bus.cmd_valid = 1'b1;
    bus.cmd       = 2'b11;
    tick();
    for (int n = 0; n < N_NEURON; n++) exp_q.push_back(expv[n]);
    if (hold_cmd) bus.cmd = 2'b01;
    else          bus.cmd_valid = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      tick();
      cyc++;
      if (cyc == 15) begin
        bus.cmd_valid = 1'b0;
        bus.cmd       = 2'b00;
      end
      if (bus.done) seen = 1'b1;
    end
    check($sformatf("%s_done_latency", tag), 32'(cyc), 32'd20);
    check($sformatf("%s_busy_at_done", tag), 32'(bus.busy), 32'd0);
    tick();
    check($sformatf("%s_done_cleared", tag), 32'(bus.done), 32'd0);
    for (int n = 0; n < N_NEURON; n++) begin
      bus.rd_sel = SEL_W'(n);
      #1;
      check($sformatf("%s_out%0d", tag, n), 32'(bus.rd_data), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt;
    int   seen_done;

    bus.cmd_valid  = 1'b0;
    bus.cmd        = 2'b00;
    bus.data_valid = 1'b0;
    bus.data_in    = '0;
    bus.rd_sel     = '0;

    // V0: all weights 1, bias 0, th 0, inputs 1..4 -> acc 10
    vt = '0;
    for (int i = 0; i < 4; i++) vt.x[i] = 8'(i + 1);
    for (int k = 0; k < 16; k++) vt.w[k] = 8'd1;
`ifdef NN_RELU_EN
    for (int n = 0; n < 4; n++) vt.exp_out[n] = 8'd10;
`else
    for (int n = 0; n < 4; n++) vt.exp_out[n] = 8'd1;
`endif
    vecs[0] = vt;

    // V1: saturation / sign / bias==th / acc == th-1
    vt = '0;
    for (int i = 0; i < 4; i++) vt.x[i] = 8'd127;
    for (int i = 0; i < 4; i++) vt.w[0*4+i] = 8'd127;
    for (int i = 0; i < 4; i++) vt.w[1*4+i] = 8'hFF;
    vt.b[2] = 8'hFB; vt.th[2] = 8'hFB;
    vt.b[3] = 8'd3;  vt.th[3] = 8'd4;
`ifdef NN_RELU_EN
    vt.exp_out[0] = 8'd127; vt.exp_out[1] = 8'd0; vt.exp_out[2] = 8'hFB; vt.exp_out[3] = 8'd0;
`else
    vt.exp_out[0] = 8'd1;   vt.exp_out[1] = 8'd0; vt.exp_out[2] = 8'd1;  vt.exp_out[3] = 8'd0;
`endif
    vecs[1] = vt;

    // V2: mixed signs, x = -3, 5, -128, 2
    vt = '0;
    vt.x[0] = 8'hFD; vt.x[1] = 8'd5; vt.x[2] = 8'h80; vt.x[3] = 8'd2;
    vt.w[0] = 8'd1; vt.w[1] = 8'd1; vt.th[0] = 8'd2;                 // 2 >= 2
    vt.w[1*4+2] = 8'hFF; vt.b[1] = 8'h9C;                             // 128-100 = 28
    vt.w[2*4+2] = 8'd1;  vt.th[2] = 8'h80;                            // -128 >= -128
    for (int i = 0; i < 4; i++) vt.w[3*4+i] = 8'h80;
    vt.b[3] = 8'hFF; vt.th[3] = 8'd127;                               // 15871 -> sat
`ifdef NN_RELU_EN
    vt.exp_out[0] = 8'd2; vt.exp_out[1] = 8'd28; vt.exp_out[2] = 8'h80; vt.exp_out[3] = 8'd127;
`else
    for (int n = 0; n < 4; n++) vt.exp_out[n] = 8'd1;
`endif
    vecs[2] = vt;

    // V3: acc 4 against thresholds 3,4,5,6
    vt = '0;
    for (int i = 0; i < 4; i++) vt.x[i] = 8'd1;
    for (int k = 0; k < 16; k++) vt.w[k] = 8'd1;
    for (int n = 0; n < 4; n++) vt.th[n] = 8'(3 + n);
`ifdef NN_RELU_EN
    vt.exp_out[0] = 8'd4; vt.exp_out[1] = 8'd4; vt.exp_out[2] = 8'd0; vt.exp_out[3] = 8'd0;
`else
    vt.exp_out[0] = 8'd1; vt.exp_out[1] = 8'd1; vt.exp_out[2] = 8'd0; vt.exp_out[3] = 8'd0;
`endif
    vecs[3] = vt;

    // Reset
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_data_ready", 32'(bus.data_ready), 32'd0);
    for (int n = 0; n < N_NEURON; n++) begin
      bus.rd_sel = SEL_W'(n);
      #1;
      check($sformatf("rst_rd%0d", n), 32'(bus.rd_data), 32'd0);
    end

    // Table-driven layers
    for (int v = 0; v < 4; v++) begin
      load_params(vecs[v], 1'b0);
      load_inputs(vecs[v]);
      run_check($sformatf("vec%0d", v), vecs[v].exp_out, 1'b0);
    end

    // Re-RUN without reload reproduces the last result
    run_check("rerun", vecs[3].exp_out, 1'b0);

    // NOP in IDLE
    for (int k = 0; k < 3; k++) issue(2'b00);
    check("nop_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("nop_busy", 32'(bus.busy), 32'd0);
    check("nop_data_ready", 32'(bus.data_ready), 32'd0);

    // Stalled parameter load, then stray beats in IDLE
    load_params(vecs[0], 1'b1);
    for (int k = 0; k < 3; k++) beat(8'h55);
    check("stray_beats_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("stray_beats_busy", 32'(bus.busy), 32'd0);
    load_inputs(vecs[0]);
    run_check("stalled", vecs[0].exp_out, 1'b0);

    // LOAD_PARAM request held during COMPUTE is ignored
    run_check("ignored_cmd", vecs[0].exp_out, 1'b1);
    check("ignored_cmd_data_ready", 32'(bus.data_ready), 32'd0);

    // Reset mid-COMPUTE
    load_params(vecs[1], 1'b0);
    load_inputs(vecs[1]);
    run_check("pre_abort", vecs[1].exp_out, 1'b0);
    bus.cmd_valid = 1'b1;
    bus.cmd       = 2'b11;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd       = 2'b00;
    for (int k = 1; k < 10; k++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("abort_done", 32'(bus.done), 32'd0);
    seen_done = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (bus.done) seen_done++;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    for (int n = 0; n < N_NEURON; n++) begin
      bus.rd_sel = SEL_W'(n);
      #1;
      check($sformatf("abort_rd%0d", n), 32'(bus.rd_data), 32'd0);
    end
    vt = '0;
`ifndef NN_RELU_EN
    for (int n = 0; n < 4; n++) vt.exp_out[n] = 8'd1;
`endif
    run_check("after_abort", vt.exp_out, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
